// File: rtl/mar_ram_unit_pkg.sv
// Shared computer package: MAR/RAM size defaults, FSM encoding and strobe polarity.
package mar_ram_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Control strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/mar_ram_unit_ram_16x8_array.sv
// Storage array: synchronous write port, asynchronous read port, contents not reset.
module ram_16x8_array #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mar_ram_unit.sv
// MAR + RAM unit: LOAD mode accepts program words, RUN mode serves bus strobes.
module mar_ram_unit
  import mar_ram_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_oe,
  input  logic                load_mar_bar,
  input  logic                ram_read_bar,
  input  logic                ram_write_bar,
  input  logic                enable_ram_bar,
  input  logic                prog_mode,
  input  logic                prog_valid,
  output logic                prog_ready,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0]   prog_data,
  output logic [ADDR_W:0]     prog_count,
  output logic [ADDR_W-1:0]   mar_q,
  output logic                access_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] rd_latch_q, rd_latch_d;
  logic [CNT_W-1:0]  prog_count_q, prog_count_d;
  logic              access_err_q, access_err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_sel, wr_sel;

  assign rd_sel = (ram_read_bar  == STROBE_ON);
  assign wr_sel = (ram_write_bar == STROBE_ON);

  // Next-state, datapath and RAM write-port selection.
  always_comb begin
    state_d      = prog_mode ? ST_LOAD : ST_RUN;
    mar_d        = mar_q;
    rd_latch_d   = rd_latch_q;
    prog_count_d = prog_count_q;
    access_err_d = access_err_q;
    ram_we       = 1'b0;
    ram_waddr    = mar_q;
    ram_wdata    = bus_in;

    if (state_q == ST_LOAD) begin
      if (prog_valid) begin
        ram_we    = 1'b1;
        ram_waddr = prog_addr;
        ram_wdata = prog_data;
        if (prog_count_q != '1) prog_count_d = prog_count_q + CNT_W'(1);
      end
    end else begin
      if (load_mar_bar == STROBE_ON) mar_d = bus_in[ADDR_W-1:0];
      if (rd_sel && wr_sel) begin
        access_err_d = 1'b1;
      end else if (rd_sel) begin
        rd_latch_d = ram_rdata;
      end else if (wr_sel) begin
        ram_we = 1'b1;
      end
      if (state_d == ST_LOAD) begin
        prog_count_d = '0;
        access_err_d = 1'b0;
      end
    end

    // A write offered while reset is held must not land in the array.
    if (!rstn) ram_we = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_LOAD;
      mar_q        <= '0;
      rd_latch_q   <= '0;
      prog_count_q <= '0;
      access_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mar_q        <= mar_d;
      rd_latch_q   <= rd_latch_d;
      prog_count_q <= prog_count_d;
      access_err_q <= access_err_d;
    end
  end

  ram_16x8_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(mar_q),
    .rdata(ram_rdata)
  );

  assign prog_ready = (state_q == ST_LOAD);
  assign bus_oe     = (state_q == ST_RUN) && (enable_ram_bar == STROBE_ON);
  assign bus_out    = bus_oe ? rd_latch_q : '0;
  assign prog_count = prog_count_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_mar_ram_unit.sv
// Bench for mar_ram_unit: directed scenarios plus random traffic against a behavioural model.
module tb_mar_ram_unit;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       load_mar_bar, ram_read_bar, ram_write_bar, enable_ram_bar;
  logic       prog_mode, prog_valid, prog_ready;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_count;
  logic [3:0] mar_q;
  logic       access_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit       m_run;
  int       m_mar;
  int       m_latch;
  int       m_cnt;
  bit       m_err;
  int       m_mem [16];

  mar_ram_unit dut (
    .clk(clk), .rstn(rstn), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .load_mar_bar(load_mar_bar), .ram_read_bar(ram_read_bar),
    .ram_write_bar(ram_write_bar), .enable_ram_bar(enable_ram_bar),
    .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_count(prog_count),
    .mar_q(mar_q), .access_err(access_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_mar = 0; m_latch = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  // One rising edge of the specified behaviour, using the inputs held before the edge.
  task automatic model_edge();
    bit rd, wr;
    if (!m_run) begin
      if (prog_valid) begin
        m_mem[prog_addr] = int'(prog_data);
        if (m_cnt < 31) m_cnt = m_cnt + 1;
      end
    end else begin
      rd = !ram_read_bar;
      wr = !ram_write_bar;
      if (rd && wr) m_err = 1'b1;
      else if (rd) m_latch = m_mem[m_mar];
      else if (wr) m_mem[m_mar] = int'(bus_in);
      if (!load_mar_bar) m_mar = int'(bus_in) % 16;
    end
    if (prog_mode) begin
      if (m_run) begin
        m_cnt = 0;
        m_err = 1'b0;
      end
      m_run = 1'b0;
    end else begin
      m_run = 1'b1;
    end
  endtask

  task automatic compare_all();
    bit exp_oe;
    exp_oe = m_run && !enable_ram_bar;
    check_eq("mar_q", 32'(mar_q), 32'(m_mar));
    check_eq("prog_count", 32'(prog_count), 32'(m_cnt));
    check_eq("access_err", 32'(access_err), 32'(m_err));
    check_eq("prog_ready", 32'(prog_ready), 32'(!m_run));
    check_eq("bus_oe", 32'(bus_oe), 32'(exp_oe));
    check_eq("bus_out", 32'(bus_out), exp_oe ? 32'(m_latch) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic pm, input logic pv, input logic [3:0] pa, input logic [7:0] pd,
                       input logic lm, input logic rr, input logic rw, input logic er,
                       input logic [7:0] bi);
    prog_mode = pm; prog_valid = pv; prog_addr = pa; prog_data = pd;
    load_mar_bar = lm; ram_read_bar = rr; ram_write_bar = rw; enable_ram_bar = er;
    bus_in = bi;
  endtask

  task automatic run_idle(input logic [7:0] bi);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, bi);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    rstn = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    model_reset();
    #3;
    compare_all();
    check_eq("rst_prog_ready", 32'(prog_ready), 32'd1);
    check_eq("rst_bus_out", 32'(bus_out), 32'd0);
    tick();
    rstn = 1'b1;

    // Program 16 back-to-back words.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 8'(8'hA0 + i), 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      check_eq("load_ready", 32'(prog_ready), 32'd1);
      check_eq("load_no_oe", 32'(bus_oe), 32'd0);
    end
    check_eq("load_count16", 32'(prog_count), 32'd16);

    // Enter RUN, load MAR from 0x35, read with the bus enabled.
    run_idle(8'h00);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h35);
    tick();
    check_eq("mar_from_bus", 32'(mar_q), 32'd5);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check_eq("read_a5", 32'(bus_out), 32'hA5);
    check_eq("read_oe", 32'(bus_oe), 32'd1);

    // Write then read-after-write at MAR=3.
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5C);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check_eq("raw_5c", 32'(bus_out), 32'h5C);

    // Illegal read+write at MAR=2.
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
    tick();
    check_eq("err_set", 32'(access_err), 32'd1);
    check_eq("err_latch_kept", 32'(bus_out), 32'h5C);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check_eq("err_mem_kept", 32'(bus_out), 32'hA2);
    check_eq("err_sticky", 32'(access_err), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    check_eq("err_clr_load", 32'(access_err), 32'd0);

    // MAR load and read on the same edge use the old MAR.
    run_idle(8'h00);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07);
    tick();
    check_eq("oldmar_read", 32'(bus_out), 32'hA1);
    check_eq("oldmar_mar", 32'(mar_q), 32'd7);

    // Reset mid-RUN with a program word offered: no write, state back to LOAD.
    drive(1'b0, 1'b1, 4'h4, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_eq("rst_mar", 32'(mar_q), 32'd0);
    check_eq("rst_oe", 32'(bus_oe), 32'd0);
    tick();
    rstn = 1'b1;
    run_idle(8'h00);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check_eq("rst_keep_a4", 32'(bus_out), 32'hA4);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03);
    tick();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check_eq("rst_keep_5c", 32'(bus_out), 32'h5C);

    // Count saturation: enter LOAD and offer 40 words.
    drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
      tick();
    end
    check_eq("count_sat", 32'(prog_count), 32'd31);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
            1'($urandom),
            4'($urandom),
            8'($urandom),
            ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1,
            ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1,
            ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1,
            1'($urandom),
            8'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mar_ram_unit.md
MAR_RAM_UNIT -- requirements
Module: mar_ram_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, the MAR and RAM address width (16 words).
REQ-002 The block SHALL have parameter DATA_W, default 8, the bus and RAM word width.
REQ-003 The block SHALL have these ports:
  - clk  in  1  single clock; all state changes on its rising edge.
  - rstn  in  1  reset; asynchronous assert, active-low.
  - bus_in  in  DATA_W  shared bus value seen by the block.
  - bus_out  out  DATA_W  RAM data driven toward the bus.
  - bus_oe  out  1  high when bus_out is valid and owns the bus.
  - load_mar_bar  in  1  active-low; load MAR from bus_in[ADDR_W-1:0].
  - ram_read_bar  in  1  active-low; read mem[MAR] into the read latch.
  - ram_write_bar  in  1  active-low; write bus_in to mem[MAR].
  - enable_ram_bar  in  1  active-low; present the read latch on the bus.
  - prog_mode  in  1  high selects LOAD (program entry) mode.
  - prog_valid  in  1  program word offered.
  - prog_ready  out  1  block accepts program words.
  - prog_addr  in  ADDR_W  program word address.
  - prog_data  in  DATA_W  program word value.
  - prog_count  out  ADDR_W+1  words accepted since LOAD was entered.
  - mar_q  out  ADDR_W  current MAR contents.
  - access_err  out  1  sticky flag for an illegal strobe combination.

Function
REQ-004 The block SHALL implement a two-state FSM: LOAD and RUN.
REQ-005 The FSM SHALL go LOAD->RUN on the first rising edge that samples prog_mode=0, and RUN->LOAD on the first rising edge that samples prog_mode=1.
REQ-006 prog_ready SHALL be 1 exactly while the state is LOAD; it is a combinational decode of the state.
REQ-007 In LOAD, a rising edge with prog_valid=1 SHALL write prog_data to mem[prog_addr] and increment prog_count.
  - Back-to-back acceptance is allowed, one word per cycle.
  - prog_count saturates at 2^(ADDR_W+1)-1.
REQ-008 On entry to LOAD, prog_count SHALL clear to 0 and access_err SHALL clear.
REQ-009 In LOAD, the four control strobes SHALL be ignored and bus_oe SHALL be 0.
REQ-010 In RUN, prog_valid SHALL be ignored and no program write occurs.
REQ-011 In RUN, an edge with load_mar_bar=0 SHALL set MAR to bus_in[ADDR_W-1:0]; MAR otherwise holds.
REQ-012 In RUN, an edge with ram_read_bar=0 and ram_write_bar=1 SHALL set the read latch to mem[MAR], using MAR as it was before that edge.
REQ-013 In RUN, an edge with ram_write_bar=0 and ram_read_bar=1 SHALL set mem[MAR] to bus_in, using the pre-edge MAR.
REQ-014 If ram_read_bar and ram_write_bar are both 0 in RUN:
  - neither operation is performed;
  - access_err SHALL set and hold until reset or LOAD entry.
REQ-015 Read latency SHALL be one cycle: data read at edge N is on bus_out from edge N onward while enable_ram_bar=0.
REQ-016 bus_oe SHALL equal (state==RUN) && !enable_ram_bar, combinationally.
REQ-017 bus_out SHALL equal the read latch when bus_oe=1, else all zeros.
REQ-018 A write and a read-latch load of the same address are never in the same cycle (REQ-014); a read in the cycle after a write SHALL return the new data.
REQ-019 mar_q SHALL reflect MAR continuously.
REQ-020 MAR arithmetic SHALL have no increment; MAR changes only by load (REQ-011) or reset.
REQ-021 Upper bus_in bits above ADDR_W SHALL be ignored on MAR load.

Reset
REQ-022 While rstn=0, the block SHALL asynchronously force:
  - state=LOAD, MAR=0, read latch=0, prog_count=0, access_err=0;
  - therefore prog_ready=1, bus_oe=0, bus_out=0.
REQ-023 RAM contents SHALL NOT be cleared by reset.
REQ-024 Reset asserted mid-RUN or mid-program-load SHALL abort the operation with no partial write.

Structure
REQ-025 ADDR_W/DATA_W defaults, the FSM state encoding (LOAD=0, RUN=1) and the strobe polarity constants SHALL live in the shared computer package.
REQ-026 The storage array SHALL be one sub-module, ram_16x8_array: synchronous write port plus asynchronous read port, no reset.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - Reset then 16 back-to-back prog_valid words (mem[i]=8'hA0+i) -> prog_ready=1 throughout, prog_count=16, no bus_oe.
  - prog_mode 1->0; then load_mar_bar=0 with bus_in=8'h35; then read; then enable_ram_bar=0 -> mar_q=5, bus_out=8'hA5, bus_oe=1 one cycle after the read.
  - RUN: MAR=3, write bus_in=8'h5C, then read at the next edge -> latch=8'h5C; bus_out=8'h5C with enable_ram_bar=0.
  - RUN: ram_read_bar=ram_write_bar=0 at MAR=2 -> access_err=1, mem[2] unchanged, latch unchanged; prog_mode=1 -> access_err=0 next edge.
  - RUN: load_mar_bar=0 (bus_in=8'h07) and ram_read_bar=0 at the same edge with MAR=1 -> latch=mem[1], mar_q=7.
  - rstn pulsed low mid-RUN -> state LOAD, mar_q=0, bus_oe=0, prog_count=0; earlier RAM contents re-readable after return to RUN.
